// File: rtl/memory_byte_loader_if.sv
// Handshake bundle between a load requester, the byte loader and a byte-wide memory.
// The loader takes the slave modport; the requester/memory side takes master.
interface memory_byte_loader_if #(parameter int ADDR_W = 16);
  logic              Start;
  logic [ADDR_W-1:0] Address;
  logic [1:0]        Size;
  logic              MemRd;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemAck;
  logic [7:0]        MemData;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic [31:0]       Data;

  modport slave (
    input  Start, Address, Size, MemAck, MemData,
    output MemRd, MemAddr, Busy, Done, Error, Data
  );

  modport master (
    output Start, Address, Size, MemAck, MemData,
    input  MemRd, MemAddr, Busy, Done, Error, Data
  );
endinterface

// File: rtl/memory_byte_loader.sv
// Assembles a 1/2/4-byte big-endian load from a byte-wide memory with a per-byte
// ack timeout. All outputs are registered copies of the next FSM state.
module memory_byte_loader #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 Clock,
  input  logic                 Reset,
  memory_byte_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DONE, ERR} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q, memaddr_q;
  logic [1:0]        size_q;
  logic [2:0]        n_q, idx_q;
  logic [7:0]        wait_q;
  logic [31:0]       asm_q, data_q;
  logic              memrd_q, busy_q, done_q, error_q;

  logic [31:0]       asm_d, ext_d;
  logic [ADDR_W-1:0] addr_d;
  logic [2:0]        n_d;
  logic              last_d, tmo_d;

  always_comb begin
    asm_d  = {asm_q[23:0], bus.MemData};
    addr_d = base_q + ADDR_W'(idx_q + 3'd1);
    last_d = (idx_q == n_q - 3'd1);
    tmo_d  = (wait_q == 8'(TIMEOUT - 1));
    case (size_q)
      2'b00:   ext_d = {24'h0, asm_d[7:0]};
      2'b01:   ext_d = {{24{asm_d[7]}}, asm_d[7:0]};
      2'b10:   ext_d = {16'h0, asm_d[15:0]};
      default: ext_d = asm_d;
    endcase
    case (bus.Size)
      2'b11:   n_d = 3'd4;
      2'b10:   n_d = 3'd2;
      default: n_d = 3'd1;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      memaddr_q <= '0;
      size_q    <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      asm_q     <= '0;
      data_q    <= '0;
      memrd_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.Start) begin
          state_q   <= FETCH;
          base_q    <= bus.Address;
          memaddr_q <= bus.Address;
          size_q    <= bus.Size;
          n_q       <= n_d;
          idx_q     <= '0;
          wait_q    <= '0;
          asm_q     <= '0;
          memrd_q   <= 1'b1;
          busy_q    <= 1'b1;
        end
        FETCH: if (bus.MemAck) begin
          asm_q  <= asm_d;
          idx_q  <= idx_q + 3'd1;
          wait_q <= '0;
          if (last_d) begin
            state_q   <= DONE;
            data_q    <= ext_d;
            memaddr_q <= '0;
            memrd_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            memaddr_q <= addr_d;
          end
        end else if (tmo_d) begin
          // Abort leaves Data holding the last good load.
          state_q   <= ERR;
          wait_q    <= '0;
          memaddr_q <= '0;
          memrd_q   <= 1'b0;
          busy_q    <= 1'b0;
          error_q   <= 1'b1;
        end else begin
          wait_q <= wait_q + 8'd1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MemRd   = memrd_q;
  assign bus.MemAddr = memaddr_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Error   = error_q;
  assign bus.Data    = data_q;
endmodule

// File: doc/memory_byte_loader.md
MEMORY_BYTE_LOADER -- requirements
Module: memory_byte_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, legal 1..255: maximum cycles to wait for MemAck per byte.
REQ-003 SHALL have port Clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1: request a load; sampled in IDLE only.
REQ-006 SHALL have port Address, input, ADDR_W: base byte address; sampled with Start.
REQ-007 SHALL have port Size, input, 2: 00 byte zero-ext, 01 byte sign-ext, 10 halfword zero-ext, 11 word; sampled with Start.
REQ-008 SHALL have port MemRd, output, 1: byte read request to memory.
REQ-009 SHALL have port MemAddr, output, ADDR_W: address of the byte being requested.
REQ-010 SHALL have port MemAck, input, 1: memory has MemData valid this cycle.
REQ-011 SHALL have port MemData, input, 8: returned byte.
REQ-012 SHALL have port Busy, output, 1: high while in FETCH.
REQ-013 SHALL have port Done, output, 1: one-cycle pulse marking successful completion.
REQ-014 SHALL have port Error, output, 1: one-cycle pulse marking a timeout abort.
REQ-015 SHALL have port Data, output, 32: last successfully assembled word.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DONE, ERR.
REQ-017 IDLE: Start=1 SHALL latch Address, Size, byte count N (1/1/2/4), and index 0, clear the assembly register, and go to FETCH; Start=0 SHALL stay in IDLE.
REQ-018 FETCH SHALL drive MemRd=1 and MemAddr=(base+index) mod 2^ADDR_W; address wrap-around past all-ones SHALL be silent.
REQ-019 FETCH with MemAck=1 SHALL shift the assembly register left 8 and load MemData into bits [7:0], increment index, and reset the wait counter.
REQ-020 First byte fetched SHALL end up most significant within the loaded width (big-endian, ascending addresses).
REQ-021 On the MemAck of byte N-1, the FSM SHALL go to DONE and Data SHALL be updated on that same edge.
REQ-022 Extension into Data: Size 00 and 10 SHALL zero-fill the upper bits; Size 01 SHALL replicate byte bit 7 into [31:8]; Size 11 SHALL load all 32 bits.
REQ-023 FETCH with MemAck=0 SHALL increment the wait counter; on reaching TIMEOUT consecutive no-ack cycles for one byte, the FSM SHALL go to ERR.
REQ-024 DONE SHALL assert Done=1 for exactly one cycle, drive MemRd=0, and return to IDLE.
REQ-025 ERR SHALL assert Error=1 for exactly one cycle, drive MemRd=0, leave Data unchanged, and return to IDLE.
REQ-026 Start outside IDLE, including during DONE and ERR, SHALL be ignored and not queued.
REQ-027 MemAck outside FETCH SHALL be ignored.
REQ-028 Latency: Start at edge k with an ack every cycle SHALL give Done high in cycle k+N+1.
REQ-029 Busy SHALL equal (state==FETCH); Done and Error SHALL never be high together.

Reset
REQ-030 Reset=1 SHALL immediately force IDLE, MemRd=0, MemAddr=0, Busy=0, Done=0, Error=0, Data=0, and clear index, wait counter and assembly register.
REQ-031 Reset mid-FETCH SHALL abort without a Done or Error pulse; Data SHALL read 0.

Verification
REQ-032 Word load, Address=0x0010, acks every cycle with bytes 0x12,0x34,0x56,0x78 -> MemAddr 0x0010..0x0013, Done 5 cycles after Start, Data=0x12345678.
REQ-033 Size=01, byte 0x9C -> Data=0xFFFFFF9C; Size=00, same byte -> Data=0x0000009C; Size=10, bytes 0xAB,0xCD -> Data=0x0000ABCD.
REQ-034 Word load at Address=0xFFFE -> MemAddr sequence 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-035 TIMEOUT=15, ack withheld on byte 2 -> Error pulse after 15 no-ack cycles, no Done, Data keeps its prior value, next Start accepted.
REQ-036 Start held high through a whole load plus stalls of 3 cycles per byte -> exactly one load, then a new load from the IDLE cycle after Done.
REQ-037 Reset asserted mid-FETCH between clock edges -> outputs 0 without waiting for a clock edge, and the next Start completes normally.
